// File: rtl/ccd_pkg.sv
// Shared types and constants for the CCD sensor emulator: pattern modes,
// Bayer sites, FSM states and the LFSR helpers.
package ccd_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SITE_G1 = 2'd0,
        SITE_R  = 2'd1,
        SITE_B  = 2'd2,
        SITE_G2 = 2'd3
    } site_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic site_t bayer_site(input logic x0, input logic y0);
        case ({y0, x0})
            2'b00:   return SITE_G1;
            2'b01:   return SITE_R;
            2'b10:   return SITE_B;
            default: return SITE_G2;
        endcase
    endfunction

    // Galois form, shifting right; taps fold in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // An all-zero state would lock the LFSR, so it is never loaded.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/ccd_pattern_pixel.sv
// Combinational pixel generator: maps (mode, x, y, bar, lfsr) to one Bayer
// raw sample. DATA_W must be between 4 and 16.
module ccd_pattern_pixel #(
    parameter int DATA_W = 10
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [2:0]        bar,
    input  logic [DATA_W-1:0] lfsr,
    output logic [DATA_W-1:0] pixel
);
    import ccd_pkg::*;

    logic [2:0] colour;
    site_t      site;
    logic       chan_on;

    // NOTE: every variable written here gets a value before any branch,
    // so no path can leave it holding its old value (which would infer a latch).
    always_comb begin
        colour  = 3'd7 - bar;
        site    = bayer_site(x[0], y[0]);
        chan_on = colour[1];
        pixel   = '0;

        case (site)
            SITE_R:  chan_on = colour[2];
            SITE_B:  chan_on = colour[0];
            default: chan_on = colour[1];
        endcase

        case (mode_t'(mode))
            MODE_RAMP:  pixel = x + y;
            MODE_BARS:  pixel = {DATA_W{chan_on}};
            MODE_CHECK: pixel = {DATA_W{x[3] ^ y[3]}};
            MODE_LFSR:  pixel = lfsr;
            default:    pixel = '0;
        endcase
    end

endmodule

// File: rtl/ccd_sensor_emu.sv
// Camera sensor emulator: raster counters, run/idle FSM, per-frame mode and
// seed latch, LFSR and registered FVAL/LVAL/DATA outputs plus frame counter.
module ccd_sensor_emu #(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 244,
    parameter int V_ACTIVE = 1024,
    parameter int V_BLANK  = 8,
    parameter int DATA_W   = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              iENABLE,
    input  logic [1:0]        iMODE,
    input  logic [15:0]       iSEED,
    output logic              oFVAL,
    output logic              oLVAL,
    output logic [DATA_W-1:0] oDATA,
    output logic [15:0]       oFrame_Cont
);
    import ccd_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    state_t            state, state_next;
    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [2:0]        bar;
    logic [BW-1:0]     bar_pos;
    mode_t             mode_q;
    logic [15:0]       lfsr;
    logic [DATA_W-1:0] pixel;
    logic              frame_end_q;

    logic running, h_last, frame_end, frame_start, in_frame, active;

    assign running     = (state == ST_RUN);
    assign h_last      = (h == H_LAST);
    assign frame_end   = running && h_last && (v == V_LAST);
    assign frame_start = iENABLE && ((state == ST_IDLE) || frame_end);
    assign in_frame    = running && (v < V_ACT);
    assign active      = in_frame && (h < H_ACT);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    // A run only stops on the final cycle of a frame, so frames are never cut short.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (iENABLE) state_next = ST_RUN;
            ST_RUN:  if (frame_end && !iENABLE) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET || !running) begin
            h       <= '0;
            v       <= '0;
            bar     <= '0;
            bar_pos <= '0;
        end else begin
            if (h_last) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end

            // Bar index is counted rather than divided out of h.
            if (h_last) begin
                bar     <= '0;
                bar_pos <= '0;
            end else if (active) begin
                if (bar_pos == BAR_LAST) begin
                    bar_pos <= '0;
                    bar     <= bar + 3'd1;
                end else begin
                    bar_pos <= bar_pos + BW'(1);
                end
            end
        end
    end

    // Mode and seed are captured only at frame start; the LFSR load is the seed latch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q <= MODE_RAMP;
            lfsr   <= '0;
        end else if (frame_start) begin
            mode_q <= mode_t'(iMODE);
            lfsr   <= seed_fix(iSEED);
        end else if (active) begin
            lfsr   <= lfsr_step(lfsr);
        end
    end

    ccd_pattern_pixel #(
        .DATA_W (DATA_W)
    ) u_pixel (
        .mode  (mode_q),
        .x     (DATA_W'(h)),
        .y     (DATA_W'(v)),
        .bar   (bar),
        .lfsr  (lfsr[DATA_W-1:0]),
        .pixel (pixel)
    );

    // Frame count goes through the same one-clock output delay as the pixel stream.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oDATA       <= '0;
            frame_end_q <= 1'b0;
            oFrame_Cont <= '0;
        end else begin
            oFVAL       <= in_frame;
            oLVAL       <= active;
            oDATA       <= active ? pixel : '0;
            frame_end_q <= frame_end;
            if (frame_end_q) oFrame_Cont <= oFrame_Cont + 16'd1;
        end
    end

endmodule

// File: tb/tb_ccd_sensor_emu.sv
// Self-checking bench for ccd_sensor_emu on a 16x4 active / 20x6 total raster:
// table vectors, hand-written corner sequences and randomized frames vs a model.
module tb_ccd_sensor_emu;

    localparam int HA   = 16;
    localparam int HB   = 4;
    localparam int VA   = 4;
    localparam int VB   = 2;
    localparam int HT   = HA + HB;
    localparam int FR   = HT * (VA + VB);
    localparam int MAXC = 400;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        iENABLE;
    logic [1:0]  iMODE;
    logic [15:0] iSEED;
    logic        oFVAL;
    logic        oLVAL;
    logic [9:0]  oDATA;
    logic [15:0] oFrame_Cont;

    ccd_sensor_emu #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .DATA_W   (10)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .iENABLE     (iENABLE),
        .iMODE       (iMODE),
        .iSEED       (iSEED),
        .oFVAL       (oFVAL),
        .oLVAL       (oLVAL),
        .oDATA       (oDATA),
        .oFrame_Cont (oFrame_Cont)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic        cap_fval [MAXC];
    logic        cap_lval [MAXC];
    logic [9:0]  cap_data [MAXC];
    logic [15:0] cap_fcnt [MAXC];

    typedef struct {
        int          mode;
        logic [15:0] seed;
        int          idx;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset;
        RESET   = 1'b1;
        iENABLE = 1'b0;
        tick;
        tick;
        RESET   = 1'b0;
    endtask

    // Pixel value straight from the pattern rules, with the LFSR stepped per active pixel index.
    function automatic logic [9:0] exp_pixel(input int mode, input logic [15:0] seed, input int x, input int y);
        logic [15:0] s;
        int          c;
        int          bit_on;
        case (mode)
            0: return 10'((x + y) % 1024);
            1: begin
                c = 7 - x / (HA / 8);
                if (y % 2 == 0) bit_on = (x % 2 == 0) ? (c >> 1) & 1 : (c >> 2) & 1;
                else            bit_on = (x % 2 == 0) ? c & 1 : (c >> 1) & 1;
                return (bit_on != 0) ? 10'h3FF : 10'h000;
            end
            2: return ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 10'h3FF : 10'h000;
            default: begin
                s = (seed == 16'h0000) ? 16'hACE1 : seed;
                for (int n = 0; n < y * HA + x; n++)
                    s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
                return s[9:0];
            end
        endcase
    endfunction

    // Reset, start from IDLE and record ncyc output samples; sample i shows raster position i.
    task automatic run(input int ncyc, input int m0, input logic [15:0] s0,
                       input int chg_at, input int m1, input logic [15:0] s1, input int drop_at);
        do_reset;
        iMODE   = m0[1:0];
        iSEED   = s0;
        iENABLE = 1'b1;
        tick;
        for (int i = 0; i < ncyc; i++) begin
            if (i == chg_at) begin
                iMODE = m1[1:0];
                iSEED = s1;
            end
            if (i == drop_at) iENABLE = 1'b0;
            tick;
            cap_fval[i] = oFVAL;
            cap_lval[i] = oLVAL;
            cap_data[i] = oDATA;
            cap_fcnt[i] = oFrame_Cont;
        end
        iENABLE = 1'b0;
    endtask

    task automatic compare_model(input string tag, input int ncyc, input int m0, input logic [15:0] s0,
                                 input int chg_at, input int m1, input logic [15:0] s1, input int drop_at);
        int          f, p, h, v, m, fc;
        logic [15:0] s;
        logic        ef, el, alive;
        logic [9:0]  ed;
        for (int i = 0; i < ncyc; i++) begin
            f     = i / FR;
            p     = i % FR;
            h     = p % HT;
            v     = p / HT;
            alive = (drop_at < 0) || (drop_at >= f * FR);
            m     = (f > 0 && chg_at >= 0 && chg_at < f * FR) ? m1 : m0;
            s     = (f > 0 && chg_at >= 0 && chg_at < f * FR) ? s1 : s0;
            ef    = alive && (v < VA);
            el    = ef && (h < HA);
            ed    = el ? exp_pixel(m, s, h, v) : 10'h000;
            fc    = 0;
            for (int g = 0; g * FR + FR <= i; g++)
                if ((drop_at < 0) || (drop_at >= g * FR)) fc++;
            check($sformatf("%s fval i=%0d", tag, i), 32'(cap_fval[i]), 32'(ef));
            check($sformatf("%s lval i=%0d", tag, i), 32'(cap_lval[i]), 32'(el));
            check($sformatf("%s data i=%0d", tag, i), 32'(cap_data[i]), 32'(ed));
            check($sformatf("%s fcnt i=%0d", tag, i), 32'(cap_fcnt[i]), 32'(fc));
        end
    endtask

    initial begin
        int cnt_f, cnt_l, rises, bad_blank;
        int rm0, rm1, rchg, rdrop;
        logic [15:0] rs0, rs1;

        vecs[0]  = '{0, 16'h0000,  45,          10'd7};
        vecs[1]  = '{0, 16'h0000,  75,          10'd18};
        vecs[2]  = '{1, 16'h0000,   0,          10'h3FF};
        vecs[3]  = '{1, 16'h0000,   4,          10'h000};
        vecs[4]  = '{1, 16'h0000,   5,          10'h3FF};
        vecs[5]  = '{1, 16'h0000,  34,          10'h000};
        vecs[6]  = '{3, 16'h0001,   0,          10'h001};
        vecs[7]  = '{3, 16'h0001,   1,          10'h000};
        vecs[8]  = '{3, 16'h0001,   2,          10'h200};
        vecs[9]  = '{3, 16'h0001, FR + 0,       10'h001};
        vecs[10] = '{3, 16'h0001, FR + 1,       10'h000};
        vecs[11] = '{3, 16'h0001, FR + 2,       10'h200};
        vecs[12] = '{3, 16'h0000,   0,          10'h0E1};
        vecs[13] = '{2, 16'h0000,   8,          10'h3FF};
        vecs[14] = '{2, 16'h0000,  2 * HT + 3,  10'h000};

        RESET   = 1'b1;
        iENABLE = 1'b0;
        iMODE   = 2'd0;
        iSEED   = 16'h0000;
        @(negedge CLK);

        // Reset state
        do_reset;
        check("reset fval", 32'(oFVAL), 0);
        check("reset lval", 32'(oLVAL), 0);
        check("reset data", 32'(oDATA), 0);
        check("reset fcnt", 32'(oFrame_Cont), 0);

        // Table-driven pattern spot checks
        foreach (vecs[k]) begin
            run(2 * FR + 10, vecs[k].mode, vecs[k].seed, -1, 0, 16'h0, -1);
            check($sformatf("vec%0d mode%0d idx%0d", k, vecs[k].mode, vecs[k].idx),
                  32'(cap_data[vecs[k].idx]), 32'(vecs[k].exp));
        end

        // Framing with continuous enable
        run(2 * FR, 0, 16'h0, -1, 0, 16'h0, -1);
        compare_model("frame", 2 * FR, 0, 16'h0, -1, 0, 16'h0, -1);
        cnt_f = 0; cnt_l = 0; rises = 0; bad_blank = 0;
        for (int i = 0; i < FR; i++) begin
            if (cap_fval[i]) cnt_f++;
            if (cap_lval[i]) cnt_l++;
            if (cap_lval[i] && (i == 0 || !cap_lval[i-1])) rises++;
            if (!cap_lval[i] && cap_data[i] != 10'h000) bad_blank++;
        end
        check("frame fval cycles", 32'(cnt_f), 80);
        check("frame lval cycles", 32'(cnt_l), 64);
        check("frame lval runs", 32'(rises), 4);
        check("frame blank data", 32'(bad_blank), 0);
        check("frame fcnt before", 32'(cap_fcnt[FR-1]), 0);
        check("frame fcnt after", 32'(cap_fcnt[FR]), 1);

        // Mode change at v=2 takes effect next frame only
        run(2 * FR, 0, 16'h0, 2 * HT, 2, 16'h0, -1);
        compare_model("modechg", 2 * FR, 0, 16'h0, 2 * HT, 2, 16'h0, -1);
        check("modechg old frame ramp", 32'(cap_data[2 * HT + 5]), 7);
        check("modechg new frame check", 32'(cap_data[FR + 8]), 32'h3FF);

        // Enable dropped at v=1: frame completes, then idle
        run(FR + 100, 1, 16'h0, -1, 0, 16'h0, HT);
        compare_model("drop", FR + 100, 1, 16'h0, -1, 0, 16'h0, HT);
        cnt_f = 0;
        for (int i = 0; i < FR + 100; i++) if (cap_fval[i]) cnt_f++;
        check("drop fval cycles", 32'(cnt_f), 80);
        check("drop final fcnt", 32'(cap_fcnt[FR + 99]), 1);
        check("drop idle fval", 32'(cap_fval[FR + 99]), 0);

        // Reset mid-line at h=7, v=2 of the second frame, then restart
        run(FR + 2 * HT + 7, 3, 16'h0001, -1, 0, 16'h0, -1);
        check("midrst fcnt before", 32'(cap_fcnt[FR + 2 * HT + 6]), 1);
        iENABLE = 1'b1;
        RESET   = 1'b1;
        tick;
        check("midrst fval", 32'(oFVAL), 0);
        check("midrst lval", 32'(oLVAL), 0);
        check("midrst data", 32'(oDATA), 0);
        check("midrst fcnt", 32'(oFrame_Cont), 0);
        RESET = 1'b0;
        tick;
        check("restart idle edge fval", 32'(oFVAL), 0);
        tick;
        check("restart fval", 32'(oFVAL), 1);
        check("restart lval", 32'(oLVAL), 1);
        check("restart px0", 32'(oDATA), 32'h001);
        tick;
        check("restart px1", 32'(oDATA), 32'h000);
        tick;
        check("restart px2", 32'(oDATA), 32'h200);
        iENABLE = 1'b0;

        // Randomized frames against the model
        for (int r = 0; r < 6; r++) begin
            rm0   = int'($urandom_range(0, 3));
            rm1   = int'($urandom_range(0, 3));
            rs0   = (r == 0) ? 16'h0000 : 16'($urandom);
            rs1   = 16'($urandom);
            rchg  = int'($urandom_range(0, 2 * FR - 1));
            rdrop = (r % 2 == 1) ? int'($urandom_range(0, 2 * FR - 1)) : -1;
            run(2 * FR + 20, rm0, rs0, rchg, rm1, rs1, rdrop);
            compare_model($sformatf("rand%0d", r), 2 * FR + 20, rm0, rs0, rchg, rm1, rs1, rdrop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
